// File: rtl/uart_rx.sv
// Multi-lane UART receiver: all lanes share one start/stop framing, lane 0's
// first two bits select the frame length, and the word is committed on done.
module uart_rx #(
  parameter int PORTCOUNT    = 5,
  parameter int CLKDIV_W     = 4,
  parameter int CLKDIV_COUNT = 10
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [PORTCOUNT-1:0]      uart_in,
  output logic [PORTCOUNT*10-1:0]   data,
  output logic [1:0]                comma_sel,
  output logic                      done,
  output logic                      rx_err
);

  typedef enum logic [2:0] {
    IDLE, START, TYPE, DATA, STOP, ERROR, WAIT_IDLE
  } state_e;

  localparam logic [CLKDIV_W-1:0] CNT_ONE  = CLKDIV_W'(1);
  localparam logic [CLKDIV_W-1:0] CNT_HALF = CLKDIV_W'(CLKDIV_COUNT / 2);
  localparam logic [CLKDIV_W-1:0] CNT_FULL = CLKDIV_W'(CLKDIV_COUNT);
  localparam logic [CLKDIV_W-1:0] CNT_IDLE = CLKDIV_W'(CLKDIV_COUNT - 1);

  logic [PORTCOUNT-1:0]    sync1_q, sync2_q;
  state_e                  state_q, state_d;
  logic [CLKDIV_W-1:0]     cnt_q, cnt_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [3:0]              len_q, len_d;
  logic [1:0]              type_q, type_d;
  logic [PORTCOUNT*10-1:0] shift_q, shift_d;
  logic                    commit_q, commit_d;
  logic [PORTCOUNT*10-1:0] data_q, data_d;
  logic [1:0]              comma_sel_q, comma_sel_d;
  logic                    done_q, done_d;
  logic                    rx_err_q, rx_err_d;

  logic all_low, all_high, tick, do_sample;

  assign all_low   = ~|sync2_q;
  assign all_high  = &sync2_q;
  assign tick      = (cnt_q == CNT_ONE);
  assign do_sample = tick && (state_q == TYPE || state_q == DATA);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= uart_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    len_d       = len_q;
    type_d      = type_q;
    shift_d     = shift_q;
    commit_d    = 1'b0;
    data_d      = data_q;
    comma_sel_d = comma_sel_q;
    done_d      = commit_q;
    rx_err_d    = 1'b0;

    // The word is published one cycle after the stop bit, together with done.
    if (commit_q) begin
      data_d      = shift_q;
      comma_sel_d = type_q;
    end

    // Sample n lands in bit 9-n of every lane (MSB first).
    for (int k = 0; k < 10; k++) begin
      if (do_sample && int'(bit_cnt_q) == 9 - k) shift_d[k*PORTCOUNT +: PORTCOUNT] = sync2_q;
    end

    case (state_q)
      IDLE: begin
        if (!all_high) begin
          state_d   = START;
          cnt_d     = CNT_HALF;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          cnt_d = CNT_FULL;
          if (all_low)       state_d = TYPE;
          else if (all_high) state_d = IDLE;
          else               state_d = ERROR;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      TYPE: begin
        if (tick) begin
          cnt_d     = CNT_FULL;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd1) begin
            type_d  = {shift_q[9*PORTCOUNT], sync2_q[0]};
            state_d = DATA;
            case ({shift_q[9*PORTCOUNT], sync2_q[0]})
              2'b01:   len_d = 4'd3;
              2'b10:   len_d = 4'd5;
              2'b11:   len_d = 4'd10;
              default: state_d = ERROR;
            endcase
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d     = CNT_FULL;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q + 4'd1 == len_q) state_d = STOP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (all_high) begin
            commit_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = ERROR;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ERROR: begin
        rx_err_d = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!all_high) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_IDLE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      len_q       <= '0;
      type_q      <= '0;
      shift_q     <= '0;
      commit_q    <= 1'b0;
      data_q      <= '0;
      comma_sel_q <= '0;
      done_q      <= 1'b0;
      rx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      len_q       <= len_d;
      type_q      <= type_d;
      shift_q     <= shift_d;
      commit_q    <= commit_d;
      data_q      <= data_d;
      comma_sel_q <= comma_sel_d;
      done_q      <= done_d;
      rx_err_q    <= rx_err_d;
    end
  end

  assign data      = data_q;
  assign comma_sel = comma_sel_q;
  assign done      = done_q;
  assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected done/rx_err events,
// a negedge monitor pops and compares them as the receiver reports.
module tb_uart_rx;

  localparam int P   = 5;
  localparam int DIV = 10;

  logic             clk;
  logic             nrst;
  logic [P-1:0]     uart_in;
  logic [P*10-1:0]  data;
  logic [1:0]       comma_sel;
  logic             done;
  logic             rx_err;

  uart_rx #(.PORTCOUNT(P), .CLKDIV_W(4), .CLKDIV_COUNT(DIV)) dut (
    .CLK(clk), .nRST(nrst), .uart_in(uart_in), .data(data),
    .comma_sel(comma_sel), .done(done), .rx_err(rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    logic [P*10-1:0] data;
    logic [1:0]    comma;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [P*10-1:0] last_good = '0;
  logic [1:0]      last_comma = '0;

  // Directed vectors: sent lane words and hand-computed received words.
  logic [9:0] sent_v [3][P];
  logic [9:0] exp_v  [3][P];
  int         len_v  [3];
  logic [1:0] com_v  [3];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [P*10-1:0] pack_exp(input int v);
    logic [P*10-1:0] w;
    for (int i = 0; i < P; i++)
      for (int k = 0; k < 10; k++) w[k*P+i] = exp_v[v][i][k];
    return w;
  endfunction

  task automatic drive(input logic [P-1:0] val, input int cycles);
    uart_in = val;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send(input int v, input logic [P-1:0] stop_val);
    exp_t e;
    logic [P-1:0] bits;
    if (&stop_val) begin
      e.is_err   = 1'b0;
      e.data     = pack_exp(v);
      e.comma    = com_v[v];
      last_good  = e.data;
      last_comma = e.comma;
    end else begin
      e.is_err = 1'b1;
      e.data   = last_good;
      e.comma  = last_comma;
    end
    e.cyc = cyc + 9 + DIV * (len_v[v] + 1);
    sb.push_back(e);
    drive('0, DIV);
    for (int j = 0; j < len_v[v]; j++) begin
      for (int i = 0; i < P; i++) bits[i] = sent_v[v][i][9-j];
      drive(bits, DIV);
    end
    drive(stop_val, DIV);
    uart_in = '1;
  endtask

  task automatic push_err(input int at_cyc);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    e.comma  = last_comma;
    e.cyc    = at_cyc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (nrst && (done || rx_err)) begin
      if (sb.size() == 0) begin
        check("spurious_event", {62'd0, done, rx_err}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_kind", {62'd0, done, rx_err}, e.is_err ? 64'd1 : 64'd2);
        check("event_data", 64'(data), 64'(e.data));
        check("event_comma_sel", 64'(comma_sel), 64'(e.comma));
        check("event_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    // Data frame, type 11.
    sent_v[0] = '{10'b11_0101_1010, 10'b10_0110_0111, 10'b00_1111_0000, 10'b11_1111_1111, 10'b01_0000_0001};
    exp_v[0]  = '{10'b11_0101_1010, 10'b10_0110_0111, 10'b00_1111_0000, 10'b11_1111_1111, 10'b01_0000_0001};
    len_v[0]  = 10; com_v[0] = 2'd3;
    // 1-flit comma, type 01: only bits 9..7 survive.
    sent_v[1] = '{10'b011_1111111, 10'b101_1111111, 10'b110_0101010, 10'b000_1111111, 10'b111_0000000};
    exp_v[1]  = '{10'b011_0000000, 10'b101_0000000, 10'b110_0000000, 10'b000_0000000, 10'b111_0000000};
    len_v[1]  = 3; com_v[1] = 2'd1;
    // 2-flit comma, type 10: bits 9..5 survive.
    sent_v[2] = '{10'b10110_10101, 10'b11111_11111, 10'b00001_11111, 10'b01010_10101, 10'b10101_01010};
    exp_v[2]  = '{10'b10110_00000, 10'b11111_00000, 10'b00001_00000, 10'b01010_00000, 10'b10101_00000};
    len_v[2]  = 5; com_v[2] = 2'd2;

    nrst = 1'b0;
    uart_in = '1;
    repeat (3) @(negedge clk);
    check("reset_data", 64'(data), 64'd0);
    check("reset_comma_sel", 64'(comma_sel), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_rx_err", 64'(rx_err), 64'd0);
    nrst = 1'b1;
    drive('1, 5);

    // Three good frames back to back with no idle between them.
    send(0, '1);
    send(1, '1);
    send(2, '1);
    drive('1, 5);

    // Stop bit low on lane 3.
    send(0, 5'b10111);
    drive('1, 20);

    // Type bits 00 on lane 0: error after the second sample.
    push_err(cyc + 29);
    drive('0, DIV);
    drive(5'b11110, DIV);
    drive(5'b01010, DIV);
    drive('1, 20);

    // Short glitch on all lanes.
    drive('0, 3);
    drive('1, 30);
    check("glitch_hold_data", 64'(data), 64'(last_good));
    check("glitch_no_pending", 64'(sb.size()), 64'd0);

    // Lane 4 skewed at mid-start, then exactly ten idle cycles.
    push_err(cyc + 9);
    drive(5'b10000, DIV);
    drive('1, DIV);
    send(1, '1);
    drive('1, 5);

    // Reset in the middle of a data frame.
    drive('0, DIV);
    drive(5'b11011, 4 * DIV);
    nrst = 1'b0;
    uart_in = '1;
    #1;
    check("midframe_reset_data", 64'(data), 64'd0);
    check("midframe_reset_comma_sel", 64'(comma_sel), 64'd0);
    check("midframe_reset_done", 64'(done), 64'd0);
    check("midframe_reset_rx_err", 64'(rx_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    last_good = '0;
    last_comma = '0;
    drive('1, 20);
    check("post_reset_data", 64'(data), 64'd0);
    send(0, '1);

    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    drive('1, 5);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter PORTCOUNT, default 5, number of parallel serial lanes.
REQ-002 SHALL have parameter CLKDIV_W, default 4, width of bit-period counter.
REQ-003 SHALL have parameter CLKDIV_COUNT, default 10, CLK cycles per bit period (even, >=4).
REQ-004 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port uart_in  input  PORTCOUNT  serial lanes, idle high, asynchronous to CLK.
REQ-007 SHALL have port data  output  PORTCOUNT*10  received word; bit k of lane i at data[k*PORTCOUNT+i].
REQ-008 SHALL have port comma_sel  output  2  frame type of last good frame (1=1-flit comma, 2=2-flit comma, 3=data).
REQ-009 SHALL have port done  output  1  one-cycle pulse, good frame received.
REQ-010 SHALL have port rx_err  output  1  one-cycle pulse, framing error.

Function
REQ-011 SHALL pass each uart_in lane through a 2-flop synchronizer (reset value 1); all behaviour below refers to synchronized lanes.
REQ-012 SHALL implement states IDLE, START, TYPE, DATA, STOP, ERROR, WAIT_IDLE.
REQ-013 IDLE: when any lane is low, SHALL go to START and load bit counter with CLKDIV_COUNT/2.
REQ-014 START: at counter expiry (mid start bit), all lanes low -> TYPE; all lanes high -> IDLE silently (glitch); mixed -> ERROR.
REQ-015 Sampling SHALL then occur every CLKDIV_COUNT cycles after the mid-start sample.
REQ-016 Frame bits SHALL arrive MSB first: sample n (n=0..) of lane i SHALL be written to bit 9-n of that lane.
REQ-017 TYPE: first two samples of lane 0, {bit9,bit8}, SHALL give frame type; 01 -> 3 data bits, 10 -> 5, 11 -> 10; 00 -> ERROR after second sample.
REQ-018 DATA: SHALL collect remaining samples until total data-bit count equals frame length, then go to STOP.
REQ-019 Bits below the frame length SHALL be stored as 0 (e.g. type 1 leaves bits 6..0 zero on every lane).
REQ-020 STOP: next sample all lanes high -> update data and comma_sel, pulse done in the following cycle, return to IDLE; any lane low -> ERROR.
REQ-021 data and comma_sel SHALL change only at done and SHALL hold otherwise; done and data update SHALL be visible in the same cycle.
REQ-022 ERROR: SHALL pulse rx_err for exactly one cycle, discard the partial frame, go to WAIT_IDLE.
REQ-023 WAIT_IDLE: SHALL return to IDLE only after all lanes are high for CLKDIV_COUNT consecutive cycles; any low lane restarts the count.
REQ-024 done and rx_err SHALL never assert in the same cycle.
REQ-025 Latency: done SHALL assert CLKDIV_COUNT/2 + (N+1)*CLKDIV_COUNT + 1 cycles after the IDLE->START transition, N = frame length.
REQ-026 A new start bit immediately after stop (no extra idle) SHALL be received correctly.

Reset
REQ-027 On nRST low: state IDLE, counters 0, synchronizers 1, data 0, comma_sel 0, done 0, rx_err 0, regardless of frame in progress.
REQ-028 After nRST deasserts mid-frame, the remainder SHALL be ignored until the lines are seen as a fresh start from IDLE.

Verification
REQ-029 Data frame, PORTCOUNT=5, CLKDIV_COUNT=10, lane 0 sends 1,1 then 8 bits, all lanes framed -> done once, comma_sel=3, data equals the word sent.
REQ-030 Type-1 frame, lane 0 bits 0,1,x -> comma_sel=1, data bits 6..0 of every lane 0, done 1 + 5+40 cycles after start.
REQ-031 Stop bit forced low on lane 3 -> rx_err one pulse, no done, data unchanged from previous frame.
REQ-032 Start glitch: all lanes low for 3 cycles then high -> no done, no rx_err, back in IDLE.
REQ-033 Lane skew: only lanes 0-3 low at mid-start -> rx_err; lines held high 10 cycles -> next good frame received.
REQ-034 nRST asserted during DATA -> all outputs 0 immediately; next full frame -> done with correct data.
